// File: rtl/counter_mon_pkg.sv
// Shared types for the counter event monitor: event codes, FSM states and
// the record carried through the event FIFO.
package counter_mon_pkg;

   localparam int CNT_W = 4;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      EVT_NONE  = 2'd0,
      EVT_WRAP  = 2'd1,
      EVT_CLEAR = 2'd2,
      EVT_JUMP  = 2'd3
   } evt_code_e;

   typedef enum logic {
      INIT  = 1'b0,
      TRACK = 1'b1
   } state_e;

   typedef struct packed {
      evt_code_e        code;
      logic [CNT_W-1:0] prev;
      logic [CNT_W-1:0] value;
   } evt_rec_t;

endpackage

// File: rtl/evt_fifo.sv
// Small event FIFO. Pointers carry one extra wrap bit so full and empty can
// be told apart without a separate occupancy counter. A push while full is
// accepted only if a pop frees a slot at the same edge.
module evt_fifo
   import counter_mon_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  evt_rec_t push_data,
   input  logic     pop,
   output logic     full,
   output logic     empty,
   output evt_rec_t head
);

   localparam int AW = $clog2(DEPTH);

   evt_rec_t   mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_pop;
   logic        do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer advance; reset empties the queue immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage write; contents need no reset because head is masked when empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/count_event_monitor.sv
// Watches a 4-bit up-counter, classifies each transition, counts wraps,
// queues wrap/clear/jump events for a valid/ready sink and keeps sticky
// error and overflow flags.
module count_event_monitor
   import counter_mon_pkg::*;
#(
   parameter int WRAP_W     = 8,
   parameter int FIFO_DEPTH = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  count_in,
   input  logic              evt_ready,
   output logic              evt_valid,
   output logic [1:0]        evt_code,
   output logic [CNT_W-1:0]  evt_prev,
   output logic [CNT_W-1:0]  evt_value,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              err_sticky,
   output logic              ovf_sticky
);

   localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

   state_e           state;
   state_e           next_state;
   logic [CNT_W-1:0] prev;
   evt_code_e        push_code;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   evt_rec_t         push_rec;
   evt_rec_t         head;

   // State register: INIT only lasts for the first edge after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= INIT;
      end else begin
         state <= next_state;
      end
   end

   // Transition classifier, checked in priority order hold/step/wrap/clear/jump
   always_comb begin
      next_state = state;
      push_code  = EVT_NONE;
      if (state == INIT) begin
         next_state = TRACK;
      end else if (count_in == prev) begin
         push_code = EVT_NONE;
      end else if ((prev != CNT_MAX) && (count_in == prev + 4'd1)) begin
         push_code = EVT_NONE;
      end else if ((prev == CNT_MAX) && (count_in == '0)) begin
         push_code = EVT_WRAP;
      end else if (count_in == '0) begin
         push_code = EVT_CLEAR;
      end else begin
         push_code = EVT_JUMP;
      end
   end

   assign push           = (push_code != EVT_NONE);
   assign push_rec.code  = push_code;
   assign push_rec.prev  = prev;
   assign push_rec.value = count_in;
   assign pop            = evt_valid && evt_ready;

   // Previous sample is refreshed on every edge, including the INIT capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev <= '0;
      end else begin
         prev <= count_in;
      end
   end

   // Wrap accumulator saturates; it counts wraps even when the event is dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_cnt <= '0;
      end else if ((push_code == EVT_WRAP) && (wrap_cnt != WRAP_MAX)) begin
         wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
   end

   // Sticky flags: jump seen, and event lost because the queue had no room
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_sticky <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         if (push_code == EVT_JUMP) begin
            err_sticky <= 1'b1;
         end
         if (push && fifo_full && !pop) begin
            ovf_sticky <= 1'b1;
         end
      end
   end

   evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_rec),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign evt_valid = !fifo_empty;
   assign evt_code  = head.code;
   assign evt_prev  = head.prev;
   assign evt_value = head.value;

endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor: a reference model predicts
// FIFO contents into a scoreboard queue, plus a hand-derived vector table
// and directed sequences for overflow, full push/pop, saturation and reset.
module tb_count_event_monitor;
   import counter_mon_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0] cnt;
      logic       rdy;
      logic       exp_valid;
      logic [1:0] exp_code;
      logic [3:0] exp_prev;
      logic [3:0] exp_value;
      logic       exp_err;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [3:0] count_in;
   logic       evt_ready;

   logic       evt_valid;
   logic [1:0] evt_code;
   logic [3:0] evt_prev;
   logic [3:0] evt_value;
   logic [1:0] wrap_cnt;
   logic       err_sticky;
   logic       ovf_sticky;

   logic       w_evt_valid;
   logic [1:0] w_evt_code;
   logic [3:0] w_evt_prev;
   logic [3:0] w_evt_value;
   logic [7:0] w_wrap_cnt;
   logic       w_err_sticky;
   logic       w_ovf_sticky;

   int vectors;
   int miscompares;

   evt_rec_t   exp_q[$];
   logic       m_track;
   logic [3:0] m_prev;
   int         m_wrap;
   int         m_wrap_wide;
   logic       m_err;
   logic       m_ovf;

   vec_t tbl[12];

   count_event_monitor #(.WRAP_W(2), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .evt_ready  (evt_ready),
      .evt_valid  (evt_valid),
      .evt_code   (evt_code),
      .evt_prev   (evt_prev),
      .evt_value  (evt_value),
      .wrap_cnt   (wrap_cnt),
      .err_sticky (err_sticky),
      .ovf_sticky (ovf_sticky)
   );

   count_event_monitor dut_wide (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .evt_ready  (evt_ready),
      .evt_valid  (w_evt_valid),
      .evt_code   (w_evt_code),
      .evt_prev   (w_evt_prev),
      .evt_value  (w_evt_value),
      .wrap_cnt   (w_wrap_cnt),
      .err_sticky (w_err_sticky),
      .ovf_sticky (w_ovf_sticky)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_track     = 1'b0;
      m_prev      = 4'd0;
      m_wrap      = 0;
      m_wrap_wide = 0;
      m_err       = 1'b0;
      m_ovf       = 1'b0;
   endtask

   // Reference behaviour of one clock edge, evaluated before the edge
   task automatic model_edge(input logic [3:0] cnt, input logic rdy);
      evt_rec_t rec;
      logic     pop;
      pop      = (exp_q.size() > 0) && rdy;
      rec.code = EVT_NONE;
      rec.prev = m_prev;
      rec.value = cnt;
      if (m_track) begin
         if (cnt == m_prev) rec.code = EVT_NONE;
         else if (m_prev != 4'd15 && cnt == m_prev + 4'd1) rec.code = EVT_NONE;
         else if (m_prev == 4'd15 && cnt == 4'd0) rec.code = EVT_WRAP;
         else if (cnt == 4'd0) rec.code = EVT_CLEAR;
         else rec.code = EVT_JUMP;
      end
      m_track = 1'b1;
      m_prev  = cnt;
      if (rec.code == EVT_WRAP) begin
         if (m_wrap < 3) m_wrap++;
         if (m_wrap_wide < 255) m_wrap_wide++;
      end
      if (rec.code == EVT_JUMP) m_err = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (rec.code != EVT_NONE) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(rec);
         else m_ovf = 1'b1;
      end
   endtask

   // Compare both instances against the scoreboard head and model flags
   task automatic check_output(input string tag);
      evt_rec_t h;
      int       v;
      v = (exp_q.size() > 0) ? 1 : 0;
      h = '0;
      if (v == 1) h = exp_q[0];
      chk({tag, " valid"}, int'(evt_valid), v);
      chk({tag, " code"}, int'(evt_code), int'(h.code));
      chk({tag, " prev"}, int'(evt_prev), int'(h.prev));
      chk({tag, " value"}, int'(evt_value), int'(h.value));
      chk({tag, " wrap"}, int'(wrap_cnt), m_wrap);
      chk({tag, " err"}, int'(err_sticky), int'(m_err));
      chk({tag, " ovf"}, int'(ovf_sticky), int'(m_ovf));
      chk({tag, " wide valid"}, int'(w_evt_valid), v);
      chk({tag, " wide head"}, int'({w_evt_code, w_evt_prev, w_evt_value}), int'(h));
      chk({tag, " wide wrap"}, int'(w_wrap_cnt), m_wrap_wide);
      chk({tag, " wide flags"}, int'({w_err_sticky, w_ovf_sticky}), int'({m_err, m_ovf}));
   endtask

   task automatic apply_stimulus(input logic [3:0] cnt, input logic rdy, input string tag);
      count_in  = cnt;
      evt_ready = rdy;
      model_edge(cnt, rdy);
      @(posedge clk);
      #1;
      check_output(tag);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_output("reset");
      rst = 1'b1;
   endtask

   // Main sequence
   initial begin
      int valid_cycles;
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      count_in    = 4'd0;
      evt_ready   = 1'b0;
      model_reset();

      tbl[0]  = '{4'd4,  1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0};
      tbl[1]  = '{4'd5,  1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0};
      tbl[2]  = '{4'd0,  1'b1, 1'b1, 2'd2, 4'd5, 4'd0, 1'b0};
      tbl[3]  = '{4'd1,  1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0};
      tbl[4]  = '{4'd2,  1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0};
      tbl[5]  = '{4'd3,  1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0};
      tbl[6]  = '{4'd4,  1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0};
      tbl[7]  = '{4'd5,  1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0};
      tbl[8]  = '{4'd6,  1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0};
      tbl[9]  = '{4'd9,  1'b1, 1'b1, 2'd3, 4'd6, 4'd9, 1'b1};
      tbl[10] = '{4'd10, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1};
      tbl[11] = '{4'd10, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1};

      apply_reset();

      // Free-running count 0..15, 0..3: one wrap event, visible for one cycle
      valid_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(4'(i % 16), 1'b1, "count");
         if (evt_valid) begin
            valid_cycles++;
            chk("count wrap record", int'({evt_code, evt_prev, evt_value}), int'({2'd1, 4'd15, 4'd0}));
            chk("count wrap cycle", i, 16);
         end
      end
      chk("count valid cycles", valid_cycles, 1);
      chk("count wrap_cnt", int'(wrap_cnt), 1);

      // Table: counter cleared mid-count, then a jump
      for (int i = 0; i < 12; i++) begin
         apply_stimulus(tbl[i].cnt, tbl[i].rdy, "table");
         chk($sformatf("tbl%0d valid", i), int'(evt_valid), int'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d record", i), int'({evt_code, evt_prev, evt_value}),
             int'({tbl[i].exp_code, tbl[i].exp_prev, tbl[i].exp_value}));
         chk($sformatf("tbl%0d err", i), int'(err_sticky), int'(tbl[i].exp_err));
         chk($sformatf("tbl%0d wrap", i), int'(wrap_cnt), 1);
      end

      // Overflow: five jumps with the sink stalled, then drain in order
      apply_stimulus(4'd3,  1'b0, "ovf");
      apply_stimulus(4'd7,  1'b0, "ovf");
      apply_stimulus(4'd12, 1'b0, "ovf");
      apply_stimulus(4'd2,  1'b0, "ovf");
      chk("ovf before drop", int'(ovf_sticky), 0);
      apply_stimulus(4'd9,  1'b0, "ovf");
      chk("ovf after drop", int'(ovf_sticky), 1);
      chk("ovf head", int'({evt_code, evt_prev, evt_value}), int'({2'd3, 4'd10, 4'd3}));
      for (int i = 0; i < 4; i++) apply_stimulus(4'd9, 1'b1, "drain");
      chk("drain empty", int'(evt_valid), 0);
      chk("drain err held", int'(err_sticky), 1);

      // Full queue with push and pop at the same edge: nothing dropped
      apply_reset();
      apply_stimulus(4'd0, 1'b0, "full");
      apply_stimulus(4'd5, 1'b0, "full");
      apply_stimulus(4'd1, 1'b0, "full");
      apply_stimulus(4'd8, 1'b0, "full");
      apply_stimulus(4'd3, 1'b0, "full");
      apply_stimulus(4'd11, 1'b1, "pushpop");
      chk("pushpop ovf", int'(ovf_sticky), 0);
      chk("pushpop head", int'({evt_code, evt_prev, evt_value}), int'({2'd3, 4'd5, 4'd1}));
      for (int i = 0; i < 4; i++) apply_stimulus(4'd11, 1'b1, "pushpop drain");
      chk("pushpop empty", int'(evt_valid), 0);
      chk("pushpop ovf end", int'(ovf_sticky), 0);

      // Five wraps saturate the narrow accumulator
      apply_reset();
      apply_stimulus(4'd0, 1'b1, "sat");
      for (int w = 0; w < 5; w++) begin
         for (int i = 1; i <= 16; i++) apply_stimulus(4'(i % 16), 1'b1, "sat");
      end
      chk("sat narrow", int'(wrap_cnt), 3);
      chk("sat wide", int'(w_wrap_cnt), 5);

      // Asynchronous reset between edges with an event pending
      apply_stimulus(4'd7, 1'b0, "pre-rst");
      chk("pre-rst valid", int'(evt_valid), 1);
      rst = 1'b0;
      #1;
      chk("async valid", int'(evt_valid), 0);
      chk("async record", int'({evt_code, evt_prev, evt_value}), 0);
      chk("async wrap", int'(wrap_cnt), 0);
      chk("async wide wrap", int'(w_wrap_cnt), 0);
      chk("async flags", int'({err_sticky, ovf_sticky}), 0);
      #2;
      rst = 1'b1;
      model_reset();
      apply_stimulus(4'd7, 1'b1, "post-rst");
      chk("post-rst no event", int'(evt_valid), 0);
      apply_stimulus(4'd8, 1'b1, "post-rst");
      chk("post-rst err", int'(err_sticky), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream consumer of the 4-bit up-counter output (`counter_sv.count`). Samples the count every cycle and classifies each transition as hold, step, wrap, clear or jump. Accumulates a saturating wrap count and queues wrap/clear/jump events in a small FIFO for a valid/ready sink. Flags counter misbehaviour with sticky error bits.

## Interface
- `WRAP_W`, default 8: width of the wrap accumulator.
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, ≥ 2.

- `clk`  in  1  rising-edge clock, shared with the counter.
- `rst`  in  1  reset; asynchronous, active-low.
- `count_in`  in  4  registered counter value.
- `evt_ready`  in  1  sink accepts the head event.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_code`  out  2  head event code.
- `evt_prev`  out  4  count before the transition.
- `evt_value`  out  4  count after the transition.
- `wrap_cnt`  out  `WRAP_W`  number of 15→0 wraps, saturating.
- `err_sticky`  out  1  a JUMP has occurred since reset.
- `ovf_sticky`  out  1  an event was dropped because the FIFO was full.

## Operation
- **States:** `INIT`, `TRACK`.
  - Reset enters `INIT`.
  - In `INIT`, the first edge captures `count_in` into `prev`, makes no classification and moves to `TRACK`.
  - `TRACK` persists until reset.
- **Classification in `TRACK`** compares `count_in` with `prev`, with priority in this order:
  - equal → HOLD, no event.
  - `prev` ≠ 15 and `count_in` = `prev`+1 → STEP, no event.
  - `prev` = 15 and `count_in` = 0 → WRAP: push `EVT_WRAP`; `wrap_cnt`++ (saturates at 2^WRAP_W−1, never rolls over).
  - `count_in` = 0 otherwise → CLEAR: push `EVT_CLEAR`. This covers a counter reset mid-count.
  - anything else → JUMP: push `EVT_JUMP`; set `err_sticky`.
- `prev` ← `count_in` on every `TRACK` edge.
- **Event record:** {code, prev, value}.
- **Event codes:** `EVT_NONE` = 0 (never pushed), `EVT_WRAP` = 1, `EVT_CLEAR` = 2, `EVT_JUMP` = 3.
- **FIFO:**
  - pop = `evt_valid` & `evt_ready`.
  - A push while full with no pop is dropped; set `ovf_sticky`; FIFO contents are unchanged.
  - A push and pop in the same cycle while full are both performed; no drop.
  - A push and pop in the same cycle while empty: the new entry is written and appears next cycle; the pop is a no-op.
- **Outputs:**
  - `evt_code`/`evt_prev`/`evt_value` show the head entry while `evt_valid`=1.
  - When empty they read 0.
  - The head entry is stable until popped.
- `wrap_cnt` and `err_sticky` update even when the event itself is dropped.
- There is no synchronous clear; sticky bits and `wrap_cnt` are cleared only by `rst`.

## Timing
- **Reset values:**
  - `evt_valid` = 0, `evt_code` = 0, `evt_prev` = 0, `evt_value` = 0.
  - `wrap_cnt` = 0, `err_sticky` = 0, `ovf_sticky` = 0.
  - FIFO empty; state `INIT`; `prev` = 0.
- **Latency:** the transition is sampled at edge k, the event is written at edge k, and `evt_valid` is high after edge k (1 cycle). `wrap_cnt` and `err_sticky` update at the same edge k.
- Throughput is one event per cycle, in and out.
- `rst` asserted mid-operation immediately empties the FIFO and clears all outputs, independent of `clk`. The first edge after deassertion is the `INIT` capture, so there is no spurious event.
- `evt_valid` must not depend combinationally on `evt_ready`.

## Structure
- **Package `counter_mon_pkg`:**
  - `CNT_W` = 4.
  - `typedef enum logic [1:0] evt_code_e`.
  - `typedef enum logic state_e` {`INIT`, `TRACK`}.
  - `typedef struct packed evt_rec_t` {code, prev, value}.
- **Sub-module `evt_fifo`:**
  - parameterised on depth; carries `evt_rec_t`.
  - ports: push/pop, full/empty, head.
  - implementation: pointers one bit wider than the address.
- **Top:** the classifier FSM, wrap accumulator and sticky flags.

## Test plan
- **Free-running counting:** reset, then count 0→15→0→3 with `evt_ready`=1 → exactly one event {1, 15, 0}; `wrap_cnt`=1; `evt_valid` high for 1 cycle, one cycle after the 15→0 edge.
- **Counter cleared mid-count:** the counter's own reset makes 5→0 → event {2, 5, 0}; `err_sticky`=0.
- **Jump:** inject 6→9 → event {3, 6, 9}; `err_sticky`=1 and stays 1 until `rst`.
- **Overflow:** `evt_ready`=0, inject 5 jumps → `evt_valid`=1 and 4 entries held in order; fifth dropped; `ovf_sticky`=1. Then raise `evt_ready` → 4 pops in order, then `evt_valid`=0.
- **Full with push and pop together:** FIFO full, push and pop in the same cycle → no drop; `ovf_sticky` stays 0; order preserved.
- **Saturation and async reset:** with `WRAP_W`=2, 5 wraps → `wrap_cnt` saturates at 3. Then assert `rst` between clock edges → all outputs read 0 before the next edge. The first sample after release produces no event.
